// File: rtl/auto_nav_pkg.sv
// Shared definitions for the auto-drive navigation blocks: state codes,
// turn direction codes and the default millisecond budgets.
package auto_nav_pkg;

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_SETTLE  = 4'd1;
    localparam logic [3:0] ST_DECIDE  = 4'd2;
    localparam logic [3:0] ST_FORWARD = 4'd3;
    localparam logic [3:0] ST_REQ     = 4'd4;
    localparam logic [3:0] ST_WAIT    = 4'd5;
    localparam logic [3:0] ST_GAP     = 4'd6;
    localparam logic [3:0] ST_COOL    = 4'd7;
    localparam logic [3:0] ST_FAULT   = 4'd8;

    typedef enum logic [3:0] {
        S_IDLE    = ST_IDLE,
        S_SETTLE  = ST_SETTLE,
        S_DECIDE  = ST_DECIDE,
        S_FORWARD = ST_FORWARD,
        S_REQ     = ST_REQ,
        S_WAIT    = ST_WAIT,
        S_GAP     = ST_GAP,
        S_COOL    = ST_COOL,
        S_FAULT   = ST_FAULT
    } state_t;

    localparam logic DIR_L = 1'b0;
    localparam logic DIR_R = 1'b1;

    localparam int SETTLE_MS_DEF       = 50;
    localparam int ACK_TIMEOUT_MS_DEF  = 20;
    localparam int TURN_TIMEOUT_MS_DEF = 1000;
    localparam int COOLDOWN_MS_DEF     = 300;
    localparam int TW_DEF              = 10;
    localparam int EXEC_TURN_MS_DEF    = 751;

    // States in which a turn request is presented to the executor.
    function automatic logic is_turn_state(input state_t s);
        return (s == S_REQ) || (s == S_WAIT);
    endfunction

endpackage

// File: rtl/auto_turn_director_if.sv
// Turn handshake between the director (master) and the turn executor (slave).
interface auto_turn_director_if;
    // is_turning is a level request held until finish_turning falls (ack) and then
    // rises again (done); turn_left/turn_right qualify it and are stable while it is high.
    logic is_turning;
    logic turn_left;
    logic turn_right;
    logic finish_turning;

    modport master (output is_turning, output turn_left, output turn_right, input finish_turning);
    modport slave  (input is_turning, input turn_left, input turn_right, output finish_turning);
endinterface

// File: rtl/ms_timer.sv
// Saturating millisecond up-counter with a synchronous clear.
module ms_timer #(
    parameter int TW = 10
) (
    input  logic          clk_ms,
    input  logic          rst_n,
    input  logic          clr,
    output logic [TW-1:0] count
);

    always_ff @(posedge clk_ms) begin
        if (!rst_n || clr) begin
            count <= '0;
        end else if (count != '1) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/auto_turn_director.sv
// Initiator side of the auto-drive turn handshake: settles the detectors, picks a
// manoeuvre and drives forward motion or a level turn request to the executor.
module auto_turn_director
    import auto_nav_pkg::*;
#(
    parameter int SETTLE_MS       = SETTLE_MS_DEF,
    parameter int ACK_TIMEOUT_MS  = ACK_TIMEOUT_MS_DEF,
    parameter int TURN_TIMEOUT_MS = TURN_TIMEOUT_MS_DEF,
    parameter int COOLDOWN_MS     = COOLDOWN_MS_DEF,
    parameter int TW              = TW_DEF
) (
    input  logic                        clk_ms,
    input  logic                        rst_n,
    input  logic                        auto_en,
    input  logic                        det_front,
    input  logic                        det_left,
    input  logic                        det_right,
    auto_turn_director_if.master        turn_bus,
    output logic                        move_forward,
    output logic                        turn_fault,
    output state_t                      dbg_state
);

    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_MS - 1);
    localparam logic [TW-1:0] ACK_LAST    = TW'(ACK_TIMEOUT_MS - 1);
    localparam logic [TW-1:0] TURN_LAST   = TW'(TURN_TIMEOUT_MS - 1);
    localparam logic [TW-1:0] COOL_LAST   = TW'(COOLDOWN_MS - 1);

    logic          auto_en_r, fin_r;
    logic [2:0]    det_r, det_prev;
    logic          front_blk, left_blk, right_blk;
    state_t        state, next_state;
    logic          dir, next_dir, pending, next_pending;
    logic          settle_restart, timer_clr;
    logic [TW-1:0] timer;
    logic          is_turning_q, turn_left_q, turn_right_q;

    // Input copies keep loading through reset so decisions start from live values.
    always_ff @(posedge clk_ms) begin
        auto_en_r <= auto_en;
        fin_r     <= turn_bus.finish_turning;
        det_r     <= {det_front, det_left, det_right};
        det_prev  <= det_r;
    end

    assign front_blk = det_r[2];
    assign left_blk  = det_r[1];
    assign right_blk = det_r[0];

    always_comb begin
        next_state     = state;
        next_dir       = dir;
        next_pending   = pending;
        settle_restart = 1'b0;
        case (state)
            S_IDLE: if (auto_en_r && !turn_fault) next_state = S_SETTLE;
            S_SETTLE: begin
                if (det_r != det_prev)          settle_restart = 1'b1;
                else if (timer == SETTLE_LAST)  next_state = S_DECIDE;
            end
            S_DECIDE: begin
                next_state = S_REQ;
                if (!front_blk) begin
                    next_state = S_FORWARD;
                end else if (!left_blk) begin
                    next_dir     = DIR_L;
                    next_pending = 1'b0;
                end else if (!right_blk) begin
                    next_dir     = DIR_R;
                    next_pending = 1'b0;
                end else begin
                    // Boxed in: a U-turn is two consecutive right turns.
                    next_dir     = DIR_R;
                    next_pending = 1'b1;
                end
            end
            S_FORWARD: if (front_blk) next_state = S_SETTLE;
            S_REQ: begin
                if (!fin_r)                 next_state = S_WAIT;
                else if (timer == ACK_LAST) next_state = S_FAULT;
            end
            S_WAIT: begin
                if (fin_r) begin
                    next_state   = pending ? S_GAP : S_COOL;
                    next_pending = 1'b0;
                end else if (timer == TURN_LAST) begin
                    next_state = S_FAULT;
                end
            end
            S_GAP: begin
                next_state = S_REQ;
                next_dir   = DIR_R;
            end
            S_COOL:  if (timer == COOL_LAST) next_state = S_SETTLE;
            S_FAULT: next_state = S_FAULT;
            default: next_state = S_IDLE;
        endcase
        if (!auto_en_r && state != S_FAULT) next_state = S_IDLE;
    end

    assign timer_clr = settle_restart || (next_state != state);

    ms_timer #(.TW(TW)) u_timer (
        .clk_ms (clk_ms),
        .rst_n  (rst_n),
        .clr    (timer_clr),
        .count  (timer)
    );

    // Outputs are decoded from next_state so they change on the same edge as state.
    always_ff @(posedge clk_ms) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            dir          <= DIR_L;
            pending      <= 1'b0;
            move_forward <= 1'b0;
            is_turning_q <= 1'b0;
            turn_left_q  <= 1'b0;
            turn_right_q <= 1'b0;
            turn_fault   <= 1'b0;
        end else begin
            state        <= next_state;
            dir          <= next_dir;
            pending      <= next_pending;
            move_forward <= (next_state == S_FORWARD) || (next_state == S_COOL);
            is_turning_q <= is_turn_state(next_state);
            turn_left_q  <= is_turn_state(next_state) && (next_dir == DIR_L);
            turn_right_q <= is_turn_state(next_state) && (next_dir == DIR_R);
            turn_fault   <= (next_state == S_FAULT);
        end
    end

    assign turn_bus.is_turning = is_turning_q;
    assign turn_bus.turn_left  = turn_left_q;
    assign turn_bus.turn_right = turn_right_q;
    assign dbg_state           = state;

endmodule
